// File: rtl/tsm_and_driver_thirdorder.sv
// ---------------------------------------------------------------------------
// tsm_and_driver_thirdorder
//
// Upstream driver and sequencer for the third-order time-sharing AND gate
// (4 shares, 2 bits per share, 3 internal register stages in the gate).
//
// - Registers one 4-share operand pair per accepted transfer and presents it
//   to the gate on gate_share1..4 (bit0 = a share, bit1 = b share).
// - Runs a seeded 64-bit Fibonacci LFSR that advances 30 steps per cycle and
//   supplies 18 bits on rand_bit and 12 bits on rand_composable_bit.
// - Tracks the gate latency with a 4-deep valid chain and captures the gate's
//   output shares into out_share1..4 with out_valid.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   seed_load, seed        load a 64-bit seed (all-zero seed becomes 64'h1)
//   in_valid / in_ready    operand handshake
//   in_share1..4           operand shares in
//   gate_share1..4         registered operand shares to the gate
//   rand_bit               18 randomness bits to the gate
//   rand_composable_bit    12 randomness bits to the gate
//   gate_out1..4           gate output shares (from its stage-3 registers)
//   out_valid, out_share1..4  registered result
//   reseed_req             fresh seed requested
//
// Optional feature macro: TSM_RESEED_REQ_EN
//   Defined: after RESEED_PERIOD cycles in RUN, reseed_req asserts and
//   in_ready is held low until the next seed_load.
//   Undefined: reseed_req is tied low and RUN lasts indefinitely.
// ---------------------------------------------------------------------------
module tsm_and_driver_thirdorder #(
   parameter int WARMUP_CYCLES = 4,
   parameter int RESEED_PERIOD = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_load,
   input  logic [63:0] seed,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_share1,
   input  logic [1:0]  in_share2,
   input  logic [1:0]  in_share3,
   input  logic [1:0]  in_share4,
   output logic [1:0]  gate_share1,
   output logic [1:0]  gate_share2,
   output logic [1:0]  gate_share3,
   output logic [1:0]  gate_share4,
   output logic [17:0] rand_bit,
   output logic [11:0] rand_composable_bit,
   input  logic        gate_out1,
   input  logic        gate_out2,
   input  logic        gate_out3,
   input  logic        gate_out4,
   output logic        out_valid,
   output logic        out_share1,
   output logic        out_share2,
   output logic        out_share3,
   output logic        out_share4,
   output logic        reseed_req
);

   typedef enum logic [1:0] {
      ST_UNSEEDED = 2'd0,
      ST_WARMUP   = 2'd1,
      ST_RUN      = 2'd2
   } state_t;

   localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);

   state_t      state_reg;
   logic [7:0]  warm_cnt_reg;
   logic [63:0] lfsr_reg;
   logic [63:0] lfsr_next;
   logic        in_ready_reg;

   logic [1:0]  gate_share1_reg, gate_share2_reg, gate_share3_reg, gate_share4_reg;
   logic [3:0]  valid_chain_reg;
   logic        out_valid_reg;
   logic        out_share1_reg, out_share2_reg, out_share3_reg, out_share4_reg;
   logic        accept;

   // 30 LFSR steps unrolled into one combinational cone; each step shifts
   // left and feeds back taps 63/62/60/59 into bit 0.
   always_comb begin
      lfsr_next = lfsr_reg;
      for (int i = 0; i < 30; i++) begin
         lfsr_next = {lfsr_next[62:0],
                      lfsr_next[63] ^ lfsr_next[62] ^ lfsr_next[60] ^ lfsr_next[59]};
      end
   end

`ifdef TSM_RESEED_REQ_EN
   localparam logic [15:0] RESEED_MATCH = 16'(RESEED_PERIOD);
   logic [15:0] reseed_cnt_reg;
   logic        reseed_req_reg;
`else
   // RESEED_PERIOD only matters when the reseed request is built.
   logic [15:0] unused_reseed_period;
   assign unused_reseed_period = 16'(RESEED_PERIOD);
`endif

   // Sequencer FSM: seed_load wins over every other transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_UNSEEDED;
         lfsr_reg       <= 64'h1;
         warm_cnt_reg   <= '0;
         in_ready_reg   <= 1'b0;
`ifdef TSM_RESEED_REQ_EN
         reseed_cnt_reg <= '0;
         reseed_req_reg <= 1'b0;
`endif
      end else if (seed_load) begin
         state_reg      <= ST_WARMUP;
         lfsr_reg       <= (seed == 64'h0) ? 64'h1 : seed;
         warm_cnt_reg   <= '0;
         in_ready_reg   <= 1'b0;
`ifdef TSM_RESEED_REQ_EN
         reseed_cnt_reg <= '0;
         reseed_req_reg <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_WARMUP: begin
               lfsr_reg <= lfsr_next;
               if (warm_cnt_reg == WARM_LAST) begin
                  state_reg    <= ST_RUN;
                  in_ready_reg <= 1'b1;
               end else begin
                  warm_cnt_reg <= warm_cnt_reg + 8'd1;
               end
            end
            ST_RUN: begin
               lfsr_reg <= lfsr_next;
`ifdef TSM_RESEED_REQ_EN
               // Counter freezes once the request is raised; only a seed
               // load releases it.
               if (!reseed_req_reg) begin
                  reseed_cnt_reg <= reseed_cnt_reg + 16'd1;
                  if (reseed_cnt_reg + 16'd1 == RESEED_MATCH) begin
                     reseed_req_reg <= 1'b1;
                     in_ready_reg   <= 1'b0;
                  end
               end
`endif
            end
            default: begin
               // UNSEEDED: LFSR holds until a seed arrives.
            end
         endcase
      end
   end

   assign accept = in_valid & in_ready_reg;

   // Operand capture, latency tracking and result capture. The chain keeps
   // shifting regardless of the sequencer state so in-flight operations
   // survive a reseed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_share1_reg <= '0;
         gate_share2_reg <= '0;
         gate_share3_reg <= '0;
         gate_share4_reg <= '0;
         valid_chain_reg <= '0;
         out_valid_reg   <= 1'b0;
         out_share1_reg  <= 1'b0;
         out_share2_reg  <= 1'b0;
         out_share3_reg  <= 1'b0;
         out_share4_reg  <= 1'b0;
      end else begin
         if (accept) begin
            gate_share1_reg <= in_share1;
            gate_share2_reg <= in_share2;
            gate_share3_reg <= in_share3;
            gate_share4_reg <= in_share4;
         end
         valid_chain_reg <= {valid_chain_reg[2:0], accept};
         out_valid_reg   <= valid_chain_reg[3];
         if (valid_chain_reg[3]) begin
            out_share1_reg <= gate_out1;
            out_share2_reg <= gate_out2;
            out_share3_reg <= gate_out3;
            out_share4_reg <= gate_out4;
         end
      end
   end

   assign in_ready            = in_ready_reg;
   assign gate_share1         = gate_share1_reg;
   assign gate_share2         = gate_share2_reg;
   assign gate_share3         = gate_share3_reg;
   assign gate_share4         = gate_share4_reg;
   assign rand_bit            = (state_reg == ST_UNSEEDED) ? 18'h0 : lfsr_reg[17:0];
   assign rand_composable_bit = (state_reg == ST_UNSEEDED) ? 12'h0 : lfsr_reg[29:18];
   assign out_valid           = out_valid_reg;
   assign out_share1          = out_share1_reg;
   assign out_share2          = out_share2_reg;
   assign out_share3          = out_share3_reg;
   assign out_share4          = out_share4_reg;
`ifdef TSM_RESEED_REQ_EN
   assign reseed_req          = reseed_req_reg;
`else
   assign reseed_req          = 1'b0;
`endif

endmodule

// File: tb/tb_tsm_and_driver_thirdorder.sv
// ---------------------------------------------------------------------------
// Testbench for tsm_and_driver_thirdorder. Includes a behavioural model of
// the 3-stage masked AND gate (fresh random masking per operation) and a
// reference model of the 30-step LFSR.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tsm_and_driver_thirdorder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        seed_load = 1'b0;
   logic [63:0] seed = 64'h0;
   logic        in_valid = 1'b0;
   logic [1:0]  in_share1 = 2'b0, in_share2 = 2'b0, in_share3 = 2'b0, in_share4 = 2'b0;
   logic        in_ready;
   logic [1:0]  gate_share1, gate_share2, gate_share3, gate_share4;
   logic [17:0] rand_bit;
   logic [11:0] rand_composable_bit;
   logic        gate_out1, gate_out2, gate_out3, gate_out4;
   logic        out_valid;
   logic        out_share1, out_share2, out_share3, out_share4;
   logic        reseed_req;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tsm_and_driver_thirdorder #(
      .WARMUP_CYCLES(4),
      .RESEED_PERIOD(8)
   ) dut (
      .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_share1(in_share1), .in_share2(in_share2), .in_share3(in_share3), .in_share4(in_share4),
      .gate_share1(gate_share1), .gate_share2(gate_share2),
      .gate_share3(gate_share3), .gate_share4(gate_share4),
      .rand_bit(rand_bit), .rand_composable_bit(rand_composable_bit),
      .gate_out1(gate_out1), .gate_out2(gate_out2), .gate_out3(gate_out3), .gate_out4(gate_out4),
      .out_valid(out_valid),
      .out_share1(out_share1), .out_share2(out_share2), .out_share3(out_share3), .out_share4(out_share4),
      .reseed_req(reseed_req)
   );

   // ---------------- gate model: 3 register stages, masked output -------
   function automatic logic [3:0] mask_shares(input logic p, input logic [31:0] r);
      return {p ^ r[0] ^ r[1] ^ r[2], r[2:0]};
   endfunction

   logic       gate_a, gate_b;
   logic [3:0] g1 = 4'h0, g2 = 4'h0, g3 = 4'h0;
   assign gate_a = gate_share1[0] ^ gate_share2[0] ^ gate_share3[0] ^ gate_share4[0];
   assign gate_b = gate_share1[1] ^ gate_share2[1] ^ gate_share3[1] ^ gate_share4[1];
   always @(posedge clk) begin
      g1 <= mask_shares(gate_a & gate_b, $urandom);
      g2 <= g1;
      g3 <= g2;
   end
   assign gate_out1 = g3[0];
   assign gate_out2 = g3[1];
   assign gate_out3 = g3[2];
   assign gate_out4 = g3[3];

   // ---------------- LFSR reference model -------------------------------
   function automatic logic [63:0] adv30(input logic [63:0] s_in);
      logic [63:0] s;
      logic        fb;
      s = s_in;
      for (int n = 0; n < 30; n++) begin
         fb = s[63] ^ s[62] ^ s[60] ^ s[59];
         s  = (s << 1) | {63'h0, fb};
      end
      return s;
   endfunction

   logic [63:0] ref_s = 64'h1;
   logic        ref_seeded = 1'b0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_s      <= 64'h1;
         ref_seeded <= 1'b0;
      end else if (seed_load) begin
         ref_s      <= (seed == 64'h0) ? 64'h1 : seed;
         ref_seeded <= 1'b1;
      end else if (ref_seeded) begin
         ref_s <= adv30(ref_s);
      end
   end

   logic [17:0] exp_rb;
   logic [11:0] exp_rc;
   assign exp_rb = ref_seeded ? ref_s[17:0]  : 18'h0;
   assign exp_rc = ref_seeded ? ref_s[29:18] : 12'h0;

   logic out_xor;
   assign out_xor = out_share1 ^ out_share2 ^ out_share3 ^ out_share4;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic a, input logic b);
      logic [1:0] r1, r2, r3;
      r1 = 2'($urandom); r2 = 2'($urandom); r3 = 2'($urandom);
      in_share1 = r1; in_share2 = r2; in_share3 = r3;
      in_share4 = {b, a} ^ r1 ^ r2 ^ r3;
      in_valid  = 1'b1;
   endtask

   // ---------------- tests ----------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks += 4;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready cyc %0d: got %b expected 0", i, in_ready); end
         if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid cyc %0d: got %b expected 0", i, out_valid); end
         if (rand_bit !== 18'h0 || rand_composable_bit !== 12'h0) begin
            errors++; $display("FAIL reset_rand cyc %0d: got %h/%h expected 0/0", i, rand_bit, rand_composable_bit);
         end
         if (reseed_req !== 1'b0) begin errors++; $display("FAIL reset_reseed_req cyc %0d: got %b expected 0", i, reseed_req); end
      end
   endtask

   task automatic test_seed_zero();
      seed = 64'h0; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      checks += 2;
      if (rand_bit !== 18'h1 || rand_composable_bit !== 12'h0) begin
         errors++; $display("FAIL seed_zero_state: got %h/%h expected 00001/000", rand_bit, rand_composable_bit);
      end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL seed_zero_ready0: got %b expected 0", in_ready); end
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks += 2;
         if (in_ready !== (k >= 4)) begin errors++; $display("FAIL warmup_ready k=%0d: got %b expected %b", k, in_ready, (k >= 4)); end
         if (rand_bit !== exp_rb || rand_composable_bit !== exp_rc) begin
            errors++; $display("FAIL warmup_rand k=%0d: got %h/%h expected %h/%h", k, rand_bit, rand_composable_bit, exp_rb, exp_rc);
         end
      end
   endtask

   task automatic test_and_truth();
      logic a, b;
      for (int c = 0; c < 4; c++) begin
         a = c[0]; b = c[1];
         drive_op(a, b);
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL truth_ready ab=%b%b: got %b expected 1", a, b, in_ready); end
         tick();
         in_valid = 1'b0;
         checks++;
         if ({gate_share4, gate_share3, gate_share2, gate_share1} !== {in_share4, in_share3, in_share2, in_share1}) begin
            errors++; $display("FAIL truth_gate_share ab=%b%b: got %h expected %h", a, b,
               {gate_share4, gate_share3, gate_share2, gate_share1}, {in_share4, in_share3, in_share2, in_share1});
         end
         for (int k = 1; k <= 5; k++) begin
            tick();
            checks += 2;
            if (out_valid !== (k == 4)) begin errors++; $display("FAIL truth_valid ab=%b%b k=%0d: got %b expected %b", a, b, k, out_valid, (k == 4)); end
            if (rand_bit !== exp_rb) begin errors++; $display("FAIL truth_rand k=%0d: got %h expected %h", k, rand_bit, exp_rb); end
            if (k == 4) begin
               checks++;
               if (out_xor !== (a & b)) begin errors++; $display("FAIL truth_result ab=%b%b: got %b expected %b", a, b, out_xor, a & b); end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic exp_res [0:199];
      logic a, b;
      int   pulses = 0;
      for (int i = 0; i < 205; i++) begin
         if (i < 200) begin
            a = 1'($urandom); b = 1'($urandom);
            exp_res[i] = a & b;
            drive_op(a, b);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         checks++;
         if (i >= 4 && i < 204) begin
            if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid op %0d: got %b expected 1", i - 4, out_valid); end
            else pulses++;
            checks++;
            if (out_xor !== exp_res[i-4]) begin errors++; $display("FAIL b2b_result op %0d: got %b expected %b", i - 4, out_xor, exp_res[i-4]); end
         end else begin
            if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle i=%0d: got %b expected 0", i, out_valid); end
         end
      end
      checks++;
      if (pulses != 200) begin errors++; $display("FAIL b2b_count: got %0d expected 200", pulses); end
   endtask

   task automatic test_gaps();
      logic [15:0] pat;
      logic        exp_res [0:15];
      logic        a, b;
      pat = 16'b0100_1100_0111_0101;
      for (int i = 0; i < 20; i++) begin
         if (i < 16 && pat[i]) begin
            a = 1'($urandom); b = 1'($urandom);
            exp_res[i] = a & b;
            drive_op(a, b);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (i >= 4) begin
            checks++;
            if (out_valid !== pat[i-4]) begin errors++; $display("FAIL gap_valid i=%0d: got %b expected %b", i, out_valid, pat[i-4]); end
            if (pat[i-4]) begin
               checks++;
               if (out_xor !== exp_res[i-4]) begin errors++; $display("FAIL gap_result op %0d: got %b expected %b", i - 4, out_xor, exp_res[i-4]); end
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_seed_inflight();
      logic exp_res [0:2];
      logic a, b;
      for (int i = 0; i < 10; i++) begin
         seed_load = 1'b0;
         in_valid  = 1'b0;
         if (i < 3) begin
            a = 1'($urandom); b = 1'($urandom);
            exp_res[i] = a & b;
            drive_op(a, b);
         end else if (i == 3) begin
            seed      = 64'hA5C3_0F1E_7700_12FE;
            seed_load = 1'b1;
         end
         tick();
         checks += 3;
         if (in_ready !== (i < 3 || i >= 7)) begin errors++; $display("FAIL inflight_ready i=%0d: got %b expected %b", i, in_ready, (i < 3 || i >= 7)); end
         if (out_valid !== (i >= 4 && i <= 6)) begin errors++; $display("FAIL inflight_valid i=%0d: got %b expected %b", i, out_valid, (i >= 4 && i <= 6)); end
         if (rand_bit !== exp_rb || rand_composable_bit !== exp_rc) begin
            errors++; $display("FAIL inflight_rand i=%0d: got %h/%h expected %h/%h", i, rand_bit, rand_composable_bit, exp_rb, exp_rc);
         end
         if (i >= 4 && i <= 6) begin
            checks++;
            if (out_xor !== exp_res[i-4]) begin errors++; $display("FAIL inflight_result op %0d: got %b expected %b", i - 4, out_xor, exp_res[i-4]); end
         end
      end
      seed_load = 1'b0;
   endtask

   task automatic test_reset_midop();
      drive_op(1'b1, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks += 2;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid i=%0d: got %b expected 0", i, out_valid); end
         if (in_ready !== 1'b0 || rand_bit !== 18'h0) begin
            errors++; $display("FAIL midreset_state i=%0d: got ready %b rand %h expected 0/0", i, in_ready, rand_bit);
         end
      end
   endtask

`ifdef TSM_RESEED_REQ_EN
   task automatic test_reseed();
      seed = 64'hDEAD_BEEF_1234_5678; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         checks += 3;
         if (in_ready !== (k >= 4 && k < 12)) begin errors++; $display("FAIL reseed_ready k=%0d: got %b expected %b", k, in_ready, (k >= 4 && k < 12)); end
         if (reseed_req !== (k >= 12)) begin errors++; $display("FAIL reseed_req k=%0d: got %b expected %b", k, reseed_req, (k >= 12)); end
         if (rand_bit !== exp_rb) begin errors++; $display("FAIL reseed_rand k=%0d: got %h expected %h", k, rand_bit, exp_rb); end
      end
      seed = 64'h0123_4567_89AB_CDEF; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      checks++;
      if (reseed_req !== 1'b0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL reseed_clear: got req %b ready %b expected 0/0", reseed_req, in_ready);
      end
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++;
         if (in_ready !== (k >= 4)) begin errors++; $display("FAIL reseed_rewarm k=%0d: got %b expected %b", k, in_ready, (k >= 4)); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_seed_zero();
`ifdef TSM_RESEED_REQ_EN
      test_reseed();
`else
      test_and_truth();
      test_back_to_back();
      test_gaps();
      test_seed_inflight();
      test_reset_midop();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tsm_and_driver_thirdorder.md
Name: tsm_and_driver_thirdorder

Overview:
- Upstream driver and sequencer for the third-order time-sharing AND gate (4 shares, 2 bits per share, 3 internal register stages).
- Registers one 4-share operand pair per accepted transfer and presents it to the gate.
- Generates a fresh 30-bit randomness word every cycle from a seeded 64-bit LFSR: 18 bits on rand_bit and 12 bits on rand_composable_bit.
- Tracks the gate's fixed latency with a valid shift chain, captures the 4 output shares and flags them valid.

Parameters:
- WARMUP_CYCLES, 4, number of LFSR cycles after a seed load during which in_ready is held low (range 1..255).
- RESEED_PERIOD, 1024, number of RUN cycles before reseed_req asserts (used only with the optional feature; range 1..65535).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- seed_load  in  1  load seed into LFSR this cycle.
- seed  in  64  LFSR seed value.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  driver accepts operand this cycle.
- in_share1..in_share4  in  2 each  operand shares; bit1 = a share, bit2 = b share.
- gate_share1..gate_share4  out  2 each  registered operands to the gate's input_share ports.
- rand_bit  out  18  to the gate's rand_bit[18:1].
- rand_composable_bit  out  12  to the gate's rand_composable_bit[12:1].
- gate_out1..gate_out4  in  1 each  gate output shares, combinational from its stage-3 registers.
- out_valid  out  1  out_share1..4 hold a valid result.
- out_share1..out_share4  out  1 each  registered result shares.
- reseed_req  out  1  fresh seed requested (constant 0 unless TSM_RESEED_REQ_EN).

Behaviour:
- Reset values: all outputs 0; LFSR state = 64'h1; FSM in UNSEEDED; valid chain cleared; warmup counter 0.
- LFSR (Fibonacci form):
  - One step: f = s[63]^s[62]^s[60]^s[59]; s <= {s[62:0], f}.
  - In WARMUP and RUN the LFSR performs 30 steps per cycle, unrolled combinationally.
  - rand_bit[18:1] = s[17:0] and rand_composable_bit[12:1] = s[29:18], both taken from the registered state.
  - In UNSEEDED the LFSR holds and the randomness outputs are 0.
- Seed load:
  - Accepted in any state; it overrides every other state transition.
  - Loads s <= seed; an all-zero seed is replaced with 64'h1.
  - The next state is WARMUP with the warmup counter cleared.
- FSM:
  - UNSEEDED: in_ready = 0; leaves only on seed_load.
  - WARMUP: in_ready = 0; the counter increments each cycle; moves to RUN when it reaches WARMUP_CYCLES-1.
  - RUN: in_ready = 1 (unless the optional feature forces it low).
- Transfer: an operand is accepted on a rising edge where in_valid & in_ready.
  - gate_shareN <= in_shareN.
  - v[0] <= 1; otherwise v[0] <= 0. gate_shareN holds its last value when no transfer occurs.
- Valid chain:
  - v[3:0] shifts every cycle: v[k] <= v[k-1].
  - When v[3] = 1 at an edge: out_shareN <= gate_outN and out_valid <= 1; otherwise out_valid <= 0 and out_shareN hold.
- Latency: a transfer at edge T gives out_valid = 1 for exactly the cycle following edge T+4. Throughput is one result per cycle, with no output backpressure.
- Pipeline behaviour around seeding and idling:
  - In-flight operations continue through a seed load or WARMUP, consuming the new stream; they are never dropped.
  - Gaps in in_valid produce matching gaps in out_valid.
- Reset mid-operation clears the valid chain immediately; no out_valid follows.

Optional Feature:
- Macro: TSM_RESEED_REQ_EN.
- With the macro defined:
  - A 16-bit counter increments each RUN cycle.
  - When the counter reaches RESEED_PERIOD, reseed_req asserts and in_ready is forced to 0; both stay that way until seed_load.
  - seed_load clears the counter and reseed_req.
- Without the macro: no counter is built, reseed_req is tied to 0, and RUN lasts indefinitely.

Test Plan:
- Reset, then 10 idle cycles -> in_ready = 0, out_valid = 0, rand_bit = 0, reseed_req = 0.
- seed = 64'h0 loaded, WARMUP_CYCLES = 4 -> LFSR holds 64'h1; in_ready rises exactly 4 cycles after the load edge; rand word matches a 30-step reference model every cycle.
- In RUN, a single transfer with unmasked a = 1, b = 1 (shares chosen so the XOR of bit1 = 1 and the XOR of bit2 = 1) -> exactly one out_valid pulse 4 edges later, with the XOR of out_share1..4 = 1. Repeat for all 4 (a, b) combinations.
- 200 back-to-back transfers with random shares -> 200 consecutive out_valid cycles, each result XOR equal to a&b in order, with no bubbles.
- seed_load asserted while 3 operations are in flight -> those 3 results still emerge correctly; in_ready is low for WARMUP_CYCLES.
- With TSM_RESEED_REQ_EN and RESEED_PERIOD = 8 -> reseed_req rises after 8 RUN cycles and in_ready drops; seed_load clears both and WARMUP restarts.
